button_capture: RTL and testbench



---
 rtl/button_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_button_capture.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_capture.sv
// Player button capture for one Simon Says round.
// Debounces the four one-hot colour buttons, rejects multi-button presses and
// packs each accepted press as a 2-bit colour into a 32-bit sequence word.
// Optional inactivity timeout is built only when BTN_TIMEOUT_EN is defined.
module button_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [3:0]  buttons_i,
  input  logic [3:0]  seq_len_i,
  output logic        colour_valid_o,
  output logic [1:0]  colour_val_o,
  output logic [31:0] seq_out_o,
  output logic [4:0]  press_count_o,
  output logic        complete_o,
  output logic        multi_err_o,
  output logic        timeout_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that makes the run reach DEBOUNCE_CYCLES is seen while the counter is one short.
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DbW-1:0] DbOne  = DbW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRelease,
    StWaitPress,
    StPressDb,
    StHeld,
    StReleaseDb,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]      snap_q, snap_d;
  logic            colour_valid_q, colour_valid_d;
  logic [1:0]      colour_val_q, colour_val_d;
  logic [31:0]     seq_q, seq_d;
  logic [4:0]      press_count_q, press_count_d;
  logic            complete_q, complete_d;
  logic            multi_err_q, multi_err_d;
`ifdef BTN_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]     to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  function automatic logic [1:0] encode(input logic [3:0] b);
    case (b)
      4'b0010: encode = 2'd1;
      4'b0100: encode = 2'd2;
      4'b1000: encode = 2'd3;
      default: encode = 2'd0;
    endcase
  endfunction

  logic       snap_onehot;
  logic [1:0] snap_colour;
  logic [4:0] count_inc;
  logic [4:0] count_target;

  assign snap_onehot  = (snap_q != 4'd0) && ((snap_q & (snap_q - 4'd1)) == 4'd0);
  assign snap_colour  = encode(snap_q);
  assign count_inc    = press_count_q + 5'd1;
  assign count_target = {1'b0, seq_len_i} + 5'd1;

  // Next-state and output decode; everything holds and pulses drop while en_i is low.
  always_comb begin
    state_d        = state_q;
    db_cnt_d       = db_cnt_q;
    snap_d         = snap_q;
    colour_valid_d = 1'b0;
    colour_val_d   = colour_val_q;
    seq_d          = seq_q;
    press_count_d  = press_count_q;
    complete_d     = complete_q;
    multi_err_d    = 1'b0;
`ifdef BTN_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    timeout_d      = timeout_q;
`endif
    if (en_i) begin
      unique case (state_q)
        StIdle: begin
          seq_d         = 32'd0;
          press_count_d = 5'd0;
          db_cnt_d      = '0;
          state_d       = StWaitRelease;
        end
        // Blocks a button still held over from the display phase.
        StWaitRelease: begin
          if (buttons_i != 4'd0) begin
            db_cnt_d = '0;
          end else if (db_cnt_q == DbLast) begin
            db_cnt_d = '0;
            state_d  = StWaitPress;
          end else begin
            db_cnt_d = db_cnt_q + DbOne;
          end
        end
        StWaitPress: begin
          if (buttons_i != 4'd0) begin
            snap_d   = buttons_i;
            db_cnt_d = DbOne;
            state_d  = StPressDb;
`ifdef BTN_TIMEOUT_EN
            to_cnt_d = 16'd0;
          end else if (to_cnt_q == ToLast) begin
            to_cnt_d   = 16'd0;
            timeout_d  = 1'b1;
            complete_d = 1'b1;
            state_d    = StDone;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
`endif
          end
        end
        StPressDb: begin
          if (buttons_i == 4'd0) begin
            db_cnt_d = '0;
            state_d  = StWaitPress;
          end else if (buttons_i != snap_q) begin
            snap_d   = buttons_i;
            db_cnt_d = DbOne;
          end else if (db_cnt_q == DbLast) begin
            db_cnt_d = '0;
            if (snap_onehot) begin
              state_d = StHeld;
            end else begin
              multi_err_d = 1'b1;
              state_d     = StWaitRelease;
            end
          end else begin
            db_cnt_d = db_cnt_q + DbOne;
          end
        end
        // Extra buttons while held are ignored; only a full release matters.
        StHeld: begin
          if (buttons_i == 4'd0) begin
            db_cnt_d = DbOne;
            state_d  = StReleaseDb;
          end
        end
        StReleaseDb: begin
          if (buttons_i != 4'd0) begin
            db_cnt_d = '0;
            state_d  = StHeld;
          end else if (db_cnt_q == DbLast) begin
            db_cnt_d       = '0;
            colour_valid_d = 1'b1;
            colour_val_d   = snap_colour;
            if (press_count_q < 5'd16) begin
              seq_d[{press_count_q[3:0], 1'b0} +: 2] = snap_colour;
              press_count_d = count_inc;
            end
            if (count_inc >= count_target) begin
              complete_d = 1'b1;
              state_d    = StDone;
            end else begin
              state_d = StWaitPress;
            end
          end else begin
            db_cnt_d = db_cnt_q + DbOne;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      db_cnt_q       <= '0;
      snap_q         <= 4'd0;
      colour_valid_q <= 1'b0;
      colour_val_q   <= 2'd0;
      seq_q          <= 32'd0;
      press_count_q  <= 5'd0;
      complete_q     <= 1'b0;
      multi_err_q    <= 1'b0;
`ifdef BTN_TIMEOUT_EN
      to_cnt_q       <= 16'd0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      db_cnt_q       <= db_cnt_d;
      snap_q         <= snap_d;
      colour_valid_q <= colour_valid_d;
      colour_val_q   <= colour_val_d;
      seq_q          <= seq_d;
      press_count_q  <= press_count_d;
      complete_q     <= complete_d;
      multi_err_q    <= multi_err_d;
`ifdef BTN_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign colour_valid_o = colour_valid_q;
  assign colour_val_o   = colour_val_q;
  assign seq_out_o      = seq_q;
  assign press_count_o  = press_count_q;
  assign complete_o     = complete_q;
  assign multi_err_o    = multi_err_q;
`ifdef BTN_TIMEOUT_EN
  assign timeout_o      = timeout_q;
`else
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_button_capture.sv
// Self-checking bench for button_capture: vector table, directed sequences and
// randomized stimulus against a run-length reference model.
module tb_button_capture;

  localparam int D = 4;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  buttons = 4'd0;
  logic [3:0]  seq_len = 4'd0;
  logic        colour_valid;
  logic [1:0]  colour_val;
  logic [31:0] seq_out;
  logic [4:0]  press_count;
  logic        complete;
  logic        multi_err;
  logic        timeout;

  button_capture #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .buttons_i     (buttons),
    .seq_len_i     (seq_len),
    .colour_valid_o(colour_valid),
    .colour_val_o  (colour_val),
    .seq_out_o     (seq_out),
    .press_count_o (press_count),
    .complete_o    (complete),
    .multi_err_o   (multi_err),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cv_pulses = 0;
  logic [1:0] last_cval = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 arming (need D zeros), 2 looking (need D equal non-zero samples),
  // 3 holding (need D zeros), 4 done. hist keeps the samples seen in the current phase.
  int         ph = 0;
  logic [3:0] hist[$];
  logic [1:0] cols[$];
  logic [3:0] held_v = 4'd0;
  int         idle_run = 0;
  logic       m_cv = 0, m_merr = 0, m_comp = 0, m_tmo = 0;
  logic [1:0] m_cval = 0;

  function automatic bit last_d_are(input logic [3:0] v);
    if (hist.size() < D) return 0;
    for (int i = 0; i < D; i++) if (hist[hist.size() - 1 - i] != v) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] m_seq();
    logic [31:0] s = 32'd0;
    for (int k = 0; k < cols.size(); k++) s[2*k +: 2] = cols[k];
    return s;
  endfunction

  task automatic model_step();
    bit prev_nz;
    m_cv = 0;
    m_merr = 0;
    if (reset) begin
      ph = 0; hist.delete(); cols.delete(); m_cval = 0; m_comp = 0; m_tmo = 0;
      idle_run = 0;
      return;
    end
    if (!en) return;
    case (ph)
      0: begin cols.delete(); hist.delete(); ph = 1; end
      1: begin
        hist.push_back(buttons);
        if (last_d_are(4'd0)) begin ph = 2; hist.delete(); idle_run = 0; end
      end
      2: begin
        prev_nz = (hist.size() > 0) && (hist[hist.size() - 1] != 4'd0);
        hist.push_back(buttons);
        if (buttons != 4'd0) begin
          idle_run = 0;
          if (last_d_are(buttons)) begin
            if ($countones(buttons) == 1) begin held_v = buttons; ph = 3; end
            else begin m_merr = 1; ph = 1; end
            hist.delete();
          end
        end else if (!prev_nz) begin
          idle_run++;
`ifdef BTN_TIMEOUT_EN
          if (idle_run == T) begin m_tmo = 1; m_comp = 1; ph = 4; end
`endif
        end
      end
      3: begin
        hist.push_back(buttons);
        if (last_d_are(4'd0)) begin
          m_cv = 1;
          m_cval = 2'($clog2(held_v));
          if (cols.size() < 16) cols.push_back(m_cval);
          if (cols.size() == int'(seq_len) + 1) begin m_comp = 1; ph = 4; end
          else ph = 2;
          hist.delete();
          idle_run = 0;
        end
      end
      default: ;
    endcase
    while (hist.size() > D) void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    if (colour_valid) begin
      cv_pulses++;
      last_cval = colour_val;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".colour_valid"}, 32'(colour_valid), 32'(m_cv));
    chk({tag, ".colour_val"},   32'(colour_val),   32'(m_cval));
    chk({tag, ".seq_out"},      seq_out,           m_seq());
    chk({tag, ".press_count"},  32'(press_count),  32'(cols.size()));
    chk({tag, ".complete"},     32'(complete),     32'(m_comp));
    chk({tag, ".multi_err"},    32'(multi_err),    32'(m_merr));
    chk({tag, ".timeout"},      32'(timeout),      32'(m_tmo));
  endtask

  task automatic run(input logic [3:0] b, input int n);
    buttons = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart(input logic [3:0] sl);
    reset = 1; en = 0; buttons = 0; seq_len = sl;
    tick();
    reset = 0; en = 1;
    cv_pulses = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  btn;
    int          n;
    logic        cv;
    logic [1:0]  cval;
    logic [31:0] seq;
    logic [4:0]  cnt;
    logic        comp;
    logic        merr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [3:0] b, int n, logic cv, logic [1:0] cval,
                              logic [31:0] s, logic [4:0] c, logic cp, logic me);
    vec_t v;
    v.rst = r; v.en = e; v.btn = b; v.n = n; v.cv = cv; v.cval = cval;
    v.seq = s; v.cnt = c; v.comp = cp; v.merr = me;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_seq;

    // Single press 0100 with seq_len=0.
    vecs.push_back(mk(1, 0, 4'h0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h4, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h4, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 1, 1, 2, 32'h2, 1, 1, 0));
    vecs.push_back(mk(0, 1, 4'h0, 1, 0, 2, 32'h2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h4, 3, 0, 2, 32'h2, 1, 1, 0));
    vecs.push_back(mk(0, 1, 4'h1, 6, 0, 2, 32'h2, 1, 1, 0));
    // Multi-button rejection, then a clean 1000.
    vecs.push_back(mk(1, 1, 4'h0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h3, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h3, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'h3, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h8, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4, 1, 3, 32'h3, 1, 1, 0));
    // Reset during press debounce, then a button held over when en rises.
    vecs.push_back(mk(1, 0, 4'h0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'h1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 6, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4, 1, 0, 32'h0, 1, 1, 0));

    seq_len = 4'd0;
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      reset = vecs[i].rst;
      en    = vecs[i].en;
      run(vecs[i].btn, vecs[i].n);
      chk({tag, ".colour_valid"}, 32'(colour_valid), 32'(vecs[i].cv));
      chk({tag, ".colour_val"},   32'(colour_val),   32'(vecs[i].cval));
      chk({tag, ".seq_out"},      seq_out,           vecs[i].seq);
      chk({tag, ".press_count"},  32'(press_count),  32'(vecs[i].cnt));
      chk({tag, ".complete"},     32'(complete),     32'(vecs[i].comp));
      chk({tag, ".multi_err"},    32'(multi_err),    32'(vecs[i].merr));
      chk({tag, ".timeout"},      32'(timeout),      32'd0);
    end
    reset = 0;

    // Four presses 0001, 1000, 0010, 0100 with seq_len=3.
    restart(4'd3);
    run(4'h0, 5);
    run(4'h1, 5); run(4'h0, 5);
    run(4'h8, 5); run(4'h0, 5);
    run(4'h2, 5); run(4'h0, 5);
    chk("seq4.complete_before_last", 32'(complete), 32'd0);
    run(4'h4, 5); run(4'h0, 5);
    chk("seq4.pulses",   32'(cv_pulses),   32'd4);
    chk("seq4.seq_out",  seq_out,          32'h0000_009C);
    chk("seq4.count",    32'(press_count), 32'd4);
    chk("seq4.complete", 32'(complete),    32'd1);

    // Bouncy 0010 must yield exactly one press.
    restart(4'd0);
    run(4'h0, 5);
    for (int i = 0; i < 10; i++) run(((i / 2) % 2 == 0) ? 4'h2 : 4'h0, 1);
    chk("bounce.no_early_pulse", 32'(cv_pulses), 32'd0);
    run(4'h2, 4);
    run(4'h0, 4);
    chk("bounce.pulses",  32'(cv_pulses),   32'd1);
    chk("bounce.cval",    32'(last_cval),   32'd1);
    chk("bounce.seq_out", seq_out,          32'h1);
    chk("bounce.count",   32'(press_count), 32'd1);

    // seq_len=15 fills the full word.
    restart(4'd15);
    run(4'h0, 5);
    exp_seq = 32'd0;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] b;
      b = 4'h1 << ((k * 3 + 1) % 4);
      exp_seq[2*k +: 2] = 2'((k * 3 + 1) % 4);
      run(b, 5);
      run(4'h0, 5);
    end
    chk("full.seq_out",  seq_out,          exp_seq);
    chk("full.count",    32'(press_count), 32'd16);
    chk("full.complete", 32'(complete),    32'd1);
    chk("full.pulses",   32'(cv_pulses),   32'd16);

`ifdef BTN_TIMEOUT_EN
    // Idle timeout with an en=0 pause in the middle of the wait.
    restart(4'd2);
    run(4'h0, 5 + 10);
    en = 0;
    run(4'h0, 7);
    en = 1;
    run(4'h0, 9);
    chk("tmo.not_yet", 32'(timeout), 32'd0);
    run(4'h0, 1);
    chk("tmo.timeout",  32'(timeout),  32'd1);
    chk("tmo.complete", 32'(complete), 32'd1);
`endif

    // Randomized rounds against the reference model.
    for (int r = 0; r < 40; r++) begin
      int cyc;
      reset = 1; en = 0; buttons = 0;
      tick();
      reset = 0;
      seq_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      cyc = 0;
      while (cyc < 300) begin
        int sel, len;
        logic [3:0] val;
        sel = $urandom_range(0, 9);
        if (sel < 4) val = 4'h0;
        else if (sel < 8) val = 4'h1 << $urandom_range(0, 3);
        else val = 4'($urandom_range(1, 15));
        len = $urandom_range(1, 7);
        for (int j = 0; j < len; j++) begin
          en = ($urandom_range(0, 9) != 0);
          reset = ($urandom_range(0, 299) == 0);
          buttons = val;
          tick();
          compare_model($sformatf("rnd%0d.c%0d", r, cyc));
          if (colour_valid && multi_err) chk("rnd.pulse_overlap", 32'd1, 32'd0);
          cyc++;
        end
      end
      reset = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
